counter_edge_primitives: RTL and testbench
==========================================

# counter_edge_primitives

Bundle of the three timing primitives used throughout the game datapath: a rising-edge detector for push buttons, a modulo-M wrap-around counter, and a saturating up-counter. The three functions are independent. They share one clock, one asynchronous reset and one synchronous clear, so parent blocks can build button, tick, delay, timeout and score logic from a single verified unit.

## Interface
Parameters:
- `MOD_M`, default 6: modulus of the wrap counter; must be at least 2.
- `MOD_N`, default 3: width of the wrap counter; requires 2^MOD_N ≥ MOD_M.
- `MAX_M`, default 7: saturation value of the saturating counter; must be at least 2.
- `MAX_N`, default 3: width of the saturating counter; requires 2^MAX_N > MAX_M.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `zera_s`  in  1: synchronous clear of both counters; the edge detector is unaffected.
- `sinal`  in  1: level input to the edge detector (e.g. a button).
- `pulso`  out  1: one-cycle pulse on each rising edge of `sinal`.
- `conta_m`  in  1: count enable for the wrap counter.
- `q_m`  out  MOD_N: wrap counter value.
- `fim_m`  out  1: high while `q_m` == MOD_M−1.
- `meio_m`  out  1: high while `q_m` == MOD_M/2−1 (integer division).
- `conta_max`  in  1: count enable for the saturating counter.
- `q_max`  out  MAX_N: saturating counter value.
- `fim_max`  out  1: high while `q_max` == MAX_M.
- `meio_max`  out  1: high while `q_max` == MAX_M/2−1 (integer division).

## Operation
- **Edge detector**
  - Two flops form a delay chain: s1 ← `sinal`, then s2 ← s1.
  - `pulso` = s1 AND NOT s2.
  - Each low→high transition of `sinal` that persists across one clock edge yields exactly one `pulso` cycle, however long `sinal` stays high.
  - A low period of one or more sampled cycles re-arms the detector.
- **Wrap counter**, evaluated each rising edge in priority order:
  - `zera_s` = 1: `q_m` ← 0.
  - Otherwise, `conta_m` = 1 and `q_m` == MOD_M−1: `q_m` ← 0.
  - Otherwise, `conta_m` = 1: `q_m` ← `q_m` + 1.
  - Otherwise `q_m` holds.
- **Saturating counter**, evaluated each rising edge in priority order:
  - `zera_s` = 1: `q_max` ← 0.
  - Otherwise, `conta_max` = 1 and `q_max` < MAX_M: `q_max` ← `q_max` + 1.
  - Otherwise `q_max` holds; it never wraps.
- **Status flags**
  - `fim_*` and `meio_*` are combinational decodes of the current Q.
  - They do not depend on the enable.
  - They stay high for as long as Q sits at the decoded value.
- **Reset precedence:** `reset` > `zera_s` > count enable.

## Timing
- **`reset` asserted, any time including mid-count:**
  - s1, s2, `q_m` and `q_max` clear without waiting for a clock edge.
  - Outputs during reset: `pulso` = 0, `q_m` = 0, `q_max` = 0, `fim_m` = 0, `fim_max` = 0.
  - `meio_m` = 1 only if MOD_M/2−1 == 0, i.e. MOD_M ∈ {2,3}.
  - `meio_max` = 1 only if MAX_M/2−1 == 0, i.e. MAX_M ∈ {2,3}.
- **`reset` released with `sinal` already high:** a pulse occurs on the first edge, because s2 starts at 0.
- **Edge latency:** `sinal` sampled high at edge k (sampled low at k−1) gives `pulso` = 1 from edge k to edge k+1.
- **Counter latency:** Q changes one edge after the enable is sampled. Flags follow Q in the same cycle.
- **Wrap boundary:** with `conta_m` held, the sequence is 0,1,…,MOD_M−1,0. `fim_m` is high for exactly one cycle per period.
- **Saturation boundary:** `conta_max` held at Q == MAX_M changes nothing; `fim_max` stays high.
- **Simultaneous `zera_s` and count enable:** the clear wins and Q = 0 after the edge.
- **Enable low:** Q and flags are stable indefinitely.

## Test plan
- **Async reset mid-count:** count `q_m` to 4 and `q_max` to 5, then pulse `reset` between edges. Q = 0 and `pulso` = 0 immediately, before the next edge.
- **Wrap:** hold `conta_m` for 8 cycles from 0. `q_m` = 1,2,3,4,5,0,1,2. `fim_m` is high only while `q_m` = 5; `meio_m` is high only while `q_m` = 2.
- **Saturate:** hold `conta_max` for 10 cycles from 0. `q_max` = 1…7, then stays at 7. `fim_max` is high from the cycle `q_max` reaches 7; `meio_max` is high only at `q_max` = 2.
- **Clear priority:** `q_m` = 3 and `q_max` = 6; assert `zera_s` together with both enables for one edge. Both Q = 0 after the edge; the next enabled edge gives 1.
- **Edge detect:** drive `sinal` high for 5 cycles, low for 1 cycle, high for 3 cycles. Exactly two `pulso` cycles, each one edge after the corresponding rise is sampled.
- **Enable gating:** `conta_m` = `conta_max` = 0 for 20 cycles at Q = 4 and Q = 3. Q and all flags are unchanged.

Source files
------------

// File: rtl/counter_edge_primitives.sv
// Game-datapath timing primitives: button rising-edge detector, modulo-M wrap
// counter and saturating up-counter sharing one clock, async reset and sync clear.
module counter_edge_primitives #(
  parameter int MOD_M = 6,
  parameter int MOD_N = 3,
  parameter int MAX_M = 7,
  parameter int MAX_N = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zera_s,
  input  logic             sinal,
  output logic             pulso,
  input  logic             conta_m,
  output logic [MOD_N-1:0] q_m,
  output logic             fim_m,
  output logic             meio_m,
  input  logic             conta_max,
  output logic [MAX_N-1:0] q_max,
  output logic             fim_max,
  output logic             meio_max
);

  localparam logic [MOD_N-1:0] M_LAST = MOD_N'(MOD_M - 1);
  localparam logic [MOD_N-1:0] M_HALF = MOD_N'(MOD_M / 2 - 1);
  localparam logic [MAX_N-1:0] X_TOP  = MAX_N'(MAX_M);
  localparam logic [MAX_N-1:0] X_HALF = MAX_N'(MAX_M / 2 - 1);

  generate
    if (MOD_M < 2 || (2 ** MOD_N) < MOD_M) begin : g_bad_mod
      $error("counter_edge_primitives: MOD_M/MOD_N out of range");
    end
    if (MAX_M < 2 || (2 ** MAX_N) <= MAX_M) begin : g_bad_max
      $error("counter_edge_primitives: MAX_M/MAX_N out of range");
    end
  endgenerate

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [MOD_N-1:0] q_m_q, q_m_d;
  logic [MAX_N-1:0] q_max_q, q_max_d;

  // Edge detector ignores zera_s so a clear never swallows a pending press.
  always_comb begin
    s1_d = sinal;
    s2_d = s1_q;

    q_m_d = q_m_q;
    if (zera_s) begin
      q_m_d = '0;
    end else if (conta_m) begin
      if (q_m_q == M_LAST) q_m_d = '0;
      else                 q_m_d = q_m_q + MOD_N'(1);
    end

    q_max_d = q_max_q;
    if (zera_s) begin
      q_max_d = '0;
    end else if (conta_max && (q_max_q < X_TOP)) begin
      q_max_d = q_max_q + MAX_N'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      q_m_q   <= '0;
      q_max_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      q_m_q   <= q_m_d;
      q_max_q <= q_max_d;
    end
  end

  // Flags decode Q only, so they hold steady whatever the enables do.
  assign pulso    = s1_q & ~s2_q;
  assign q_m      = q_m_q;
  assign fim_m    = (q_m_q == M_LAST);
  assign meio_m   = (q_m_q == M_HALF);
  assign q_max    = q_max_q;
  assign fim_max  = (q_max_q == X_TOP);
  assign meio_max = (q_max_q == X_HALF);

endmodule

// File: tb/tb_counter_edge_primitives.sv
// Scoreboard bench for counter_edge_primitives: a driver predicts every cycle's
// outputs from an arithmetic model, a monitor pops and compares them.
module tb_counter_edge_primitives;

  localparam int MOD_M = 6;
  localparam int MOD_N = 3;
  localparam int MAX_M = 7;
  localparam int MAX_N = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             zera_s = 1'b0;
  logic             sinal = 1'b0;
  logic             pulso;
  logic             conta_m = 1'b0;
  logic [MOD_N-1:0] q_m;
  logic             fim_m;
  logic             meio_m;
  logic             conta_max = 1'b0;
  logic [MAX_N-1:0] q_max;
  logic             fim_max;
  logic             meio_max;

  counter_edge_primitives #(
    .MOD_M(MOD_M), .MOD_N(MOD_N), .MAX_M(MAX_M), .MAX_N(MAX_N)
  ) dut (
    .clock(clock), .reset(reset), .zera_s(zera_s), .sinal(sinal), .pulso(pulso),
    .conta_m(conta_m), .q_m(q_m), .fim_m(fim_m), .meio_m(meio_m),
    .conta_max(conta_max), .q_max(q_max), .fim_max(fim_max), .meio_max(meio_max)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             pulso;
    logic [MOD_N-1:0] q_m;
    logic             fim_m;
    logic             meio_m;
    logic [MAX_N-1:0] q_max;
    logic             fim_max;
    logic             meio_max;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: counts as integers, sinal history as the last two samples.
  int m_cnt = 0;
  int x_cnt = 0;
  bit s_last = 1'b0;
  bit s_prev = 1'b0;

  function automatic obs_t model_out();
    obs_t e;
    e.pulso    = s_last && !s_prev;
    e.q_m      = MOD_N'(m_cnt);
    e.fim_m    = (m_cnt == MOD_M - 1);
    e.meio_m   = (m_cnt == MOD_M / 2 - 1);
    e.q_max    = MAX_N'(x_cnt);
    e.fim_max  = (x_cnt == MAX_M);
    e.meio_max = (x_cnt == MAX_M / 2 - 1);
    return e;
  endfunction

  task automatic push(input string tag);
    exp_q.push_back(model_out());
    tag_q.push_back(tag);
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, predict.
  task automatic tick(input bit s, input bit cm, input bit cx, input bit z, input string tag);
    sinal = s; conta_m = cm; conta_max = cx; zera_s = z;
    @(posedge clock);
    #1;
    s_prev = s_last;
    s_last = s;
    if (z) begin
      m_cnt = 0;
      x_cnt = 0;
    end else begin
      if (cm) m_cnt = (m_cnt + 1) % MOD_M;
      if (cx && x_cnt < MAX_M) x_cnt = x_cnt + 1;
    end
    push(tag);
  endtask

  // Reset pulse placed between edges; outputs are checked before the next edge.
  task automatic do_reset(input bit s_during);
    @(negedge clock);
    #2;
    sinal = s_during;
    m_cnt = 0; x_cnt = 0; s_last = 1'b0; s_prev = 1'b0;
    push("async_reset");
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  obs_t  mon_a, mon_e;
  string mon_t;
  initial begin
    forever begin
      @(negedge clock or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        mon_a = {pulso, q_m, fim_m, meio_m, q_max, fim_max, meio_max};
        n_tests++;
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL %s t=%0t: got pulso=%b q_m=%0d fim_m=%b meio_m=%b q_max=%0d fim_max=%b meio_max=%b, expected pulso=%b q_m=%0d fim_m=%b meio_m=%b q_max=%0d fim_max=%b meio_max=%b",
                   mon_t, $time, mon_a.pulso, mon_a.q_m, mon_a.fim_m, mon_a.meio_m,
                   mon_a.q_max, mon_a.fim_max, mon_a.meio_max,
                   mon_e.pulso, mon_e.q_m, mon_e.fim_m, mon_e.meio_m,
                   mon_e.q_max, mon_e.fim_max, mon_e.meio_max);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(1'b0);

    for (int i = 0; i < 5; i++) tick(1'b0, i < 4, 1'b1, 1'b0, "count_up");
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, "wrap");

    do_reset(1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, "saturate");

    do_reset(1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, i < 3, 1'b1, 1'b0, "clr_setup");
    tick(1'b0, 1'b1, 1'b1, 1'b1, "clear_priority");
    tick(1'b0, 1'b1, 1'b1, 1'b0, "after_clear");

    tick(1'b0, 1'b0, 1'b0, 1'b0, "edge_idle");
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, "edge_high5");
    tick(1'b0, 1'b0, 1'b0, 1'b0, "edge_low1");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, "edge_high3");
    for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "edge_tail");

    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, i < 3, 1'b0, "gate_setup");
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "enable_gating");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(59) == 0) begin
        do_reset(1'($urandom_range(1)));
      end else begin
        tick(1'($urandom_range(1)), 1'($urandom_range(3) != 0),
             1'($urandom_range(3) != 0), 1'($urandom_range(9) == 0), "random");
      end
    end

    repeat (3) @(posedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
